reaction_timer_core: RTL and testbench

Consumer-side control core for the reaction-timer demo on the Nexys4 DDR board.
- Takes the 1 ms tick produced by the clock divider, plus debounced start and stop buttons.
- After a randomised hold-off it lights a stimulus LED, then measures the reaction in milliseconds.
- Reports a valid result, an early press ("cheat") or a timeout to the display/LED logic.

---
 rtl/reaction_timer_core.sv | 179 +++++++++++++++++
 tb/tb_reaction_timer_core.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_core.sv
// reaction_timer_core
//
// Control core for the reaction-timer demo. After a start press it waits a
// randomised hold-off (MIN_DELAY_MS plus a random 0..2^RAND_BITS-1 ms), lights
// the stimulus LED and counts milliseconds until the stop press. The outcome is
// a valid result, an early press (cheat) or a timeout.
//
// Optional feature macro: REACTION_BEST_EN
//   defined   -> best_ms tracks the minimum valid result since reset
//   undefined -> best_ms is tied to all-ones, no register or comparator built
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   ms_tick      one-clk pulse per millisecond
//   start_btn    debounced start button (level)
//   stop_btn     debounced reaction button (level)
//   stim_led     stimulus LED, high while measuring
//   busy         high while arming or measuring
//   result_ms    latched reaction time in ms
//   result_valid result_ms holds a genuine measurement
//   early        stop pressed before the stimulus
//   timeout      no press within TIMEOUT_MS
//   best_ms      best (minimum) valid result

module reaction_timer_core #(
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 11,
    parameter int unsigned TIMEOUT_MS   = 9999,
    parameter int unsigned CNT_W        = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ms_tick,
    input  logic             start_btn,
    input  logic             stop_btn,
    output logic             stim_led,
    output logic             busy,
    output logic [CNT_W-1:0] result_ms,
    output logic             result_valid,
    output logic             early,
    output logic             timeout,
    output logic [CNT_W-1:0] best_ms
);

    localparam logic [CNT_W-1:0] MinDelay   = CNT_W'(MIN_DELAY_MS);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_MS);
    localparam logic [CNT_W-1:0] TimeoutM1  = CNT_W'(TIMEOUT_MS - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StGo,
        StDone,
        StEarly,
        StTout
    } stateT;

    stateT            state;
    logic [15:0]      lfsr;
    logic             startPrev;
    logic             stopPrev;
    logic [CNT_W-1:0] delayCnt;
    logic [CNT_W-1:0] reactCnt;

    logic             lfsrFb;
    logic             startEdge;
    logic             stopEdge;
    logic [CNT_W-1:0] randPart;

    // Taps 16,14,13,11; the non-zero seed keeps it out of the lock-up state.
    assign lfsrFb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // Previous-value registers reset high so a button held through reset is
    // not seen as a press.
    assign startEdge = start_btn & ~startPrev;
    assign stopEdge  = stop_btn & ~stopPrev;
    assign randPart  = CNT_W'(lfsr[RAND_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            lfsr         <= 16'hACE1;
            startPrev    <= 1'b1;
            stopPrev     <= 1'b1;
            delayCnt     <= '0;
            reactCnt     <= '0;
            stim_led     <= 1'b0;
            busy         <= 1'b0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            early        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            lfsr      <= {lfsr[14:0], lfsrFb};
            startPrev <= start_btn;
            stopPrev  <= stop_btn;

            case (state)
                StIdle, StDone, StEarly, StTout: begin
                    // A stop edge coinciding with start is simply dropped.
                    if (startEdge) begin
                        delayCnt     <= MinDelay + randPart;
                        result_ms    <= '0;
                        result_valid <= 1'b0;
                        early        <= 1'b0;
                        timeout      <= 1'b0;
                        busy         <= 1'b1;
                        state        <= StArm;
                    end
                end

                StArm: begin
                    // Stop has priority over the final hold-off tick.
                    if (stopEdge) begin
                        early     <= 1'b1;
                        result_ms <= '0;
                        busy      <= 1'b0;
                        state     <= StEarly;
                    end else if (ms_tick) begin
                        if (delayCnt == CntOne) begin
                            reactCnt <= '0;
                            stim_led <= 1'b1;
                            state    <= StGo;
                        end else begin
                            delayCnt <= delayCnt - CntOne;
                        end
                    end
                end

                StGo: begin
                    // Stop has priority; a coincident tick is not counted.
                    if (stopEdge) begin
                        result_ms    <= reactCnt;
                        result_valid <= 1'b1;
                        stim_led     <= 1'b0;
                        busy         <= 1'b0;
                        state        <= StDone;
                    end else if (ms_tick) begin
                        if (reactCnt == TimeoutM1) begin
                            timeout      <= 1'b1;
                            result_ms    <= TimeoutVal;
                            result_valid <= 1'b0;
                            stim_led     <= 1'b0;
                            busy         <= 1'b0;
                            state        <= StTout;
                        end else begin
                            reactCnt <= reactCnt + CntOne;
                        end
                    end
                end

                default: begin
                    stim_led <= 1'b0;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

`ifdef REACTION_BEST_EN
    logic [CNT_W-1:0] bestQ;

    // Updated only on entry to DONE; early and timeout outcomes never count.
    always_ff @(posedge clk) begin
        if (reset) begin
            bestQ <= '1;
        end else if ((state == StGo) && stopEdge && (reactCnt < bestQ)) begin
            bestQ <= reactCnt;
        end
    end

    assign best_ms = bestQ;
`else
    assign best_ms = '1;
`endif

endmodule

// File: tb/tb_reaction_timer_core.sv
`timescale 1ns/1ps

module tb_reaction_timer_core;

    localparam int MinDelay  = 4;
    localparam int RandBits  = 2;
    localparam int TimeoutMs = 20;
    localparam int CntW      = 8;
    localparam int ArmMax    = MinDelay + (1 << RandBits) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ms_tick = 1'b0;
    logic            start_btn = 1'b0;
    logic            stop_btn = 1'b0;
    logic            stim_led;
    logic            busy;
    logic [CntW-1:0] result_ms;
    logic            result_valid;
    logic            early;
    logic            timeout;
    logic [CntW-1:0] best_ms;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int res;
        int valid;
        int early;
        int tout;
        int best;
    } expT;

    expT expQ[$];
    int  bestModel = 255;
    bit  stimSeen = 1'b0;
    bit  prevBusy = 1'b0;

    reaction_timer_core #(
        .MIN_DELAY_MS(MinDelay),
        .RAND_BITS   (RandBits),
        .TIMEOUT_MS  (TimeoutMs),
        .CNT_W       (CntW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ms_tick     (ms_tick),
        .start_btn   (start_btn),
        .stop_btn    (stop_btn),
        .stim_led    (stim_led),
        .busy        (busy),
        .result_ms   (result_ms),
        .result_valid(result_valid),
        .early       (early),
        .timeout     (timeout),
        .best_ms     (best_ms)
    );

    always #5 clk = ~clk;

    // ms_tick: one clk high every 10 clks.
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            div = (div == 9) ? 0 : div + 1;
            ms_tick = (div == 9);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: best is the minimum valid result since reset when the feature
    // is built, otherwise constant all-ones.
    task automatic noteValid(input int k);
`ifdef REACTION_BEST_EN
        if (k < bestModel) bestModel = k;
`endif
    endtask

    task automatic pushExp(input int res, input int valid, input int er, input int to);
        expT e;
        e.res = res; e.valid = valid; e.early = er; e.tout = to; e.best = bestModel;
        expQ.push_back(e);
    endtask

    // Monitor: an outcome is presented when busy falls outside reset.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (stim_led) stimSeen = 1'b1;
            if (!reset && prevBusy && !busy) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_outcome: result_ms=%0d valid=%0d early=%0d timeout=%0d",
                             result_ms, result_valid, early, timeout);
                end else begin
                    e = expQ.pop_front();
                    check("result_ms", int'(result_ms), e.res);
                    check("result_valid", int'(result_valid), e.valid);
                    check("early", int'(early), e.early);
                    check("timeout", int'(timeout), e.tout);
                    check("stim_led_off", int'(stim_led), 0);
                    check("best_ms", int'(best_ms), e.best);
                end
            end
            prevBusy = busy;
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pressStart();
        start_btn = 1'b1;
        @(posedge clk);
        #1;
        start_btn = 1'b0;
    endtask

    task automatic pressStop();
        stop_btn = 1'b1;
        @(posedge clk);
        #1;
        stop_btn = 1'b0;
    endtask

    // Counts hold-off ticks until the stimulus LED lights; ends on a negedge.
    task automatic waitStim(output int ticks);
        bit ok;
        ticks = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (ms_tick) ticks++;
            @(negedge clk);
            if (stim_led) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok || ticks < MinDelay || ticks > ArmMax) begin
            fails++;
            $display("FAIL arm_ticks: got %0d (stim=%0d), expected %0d..%0d",
                     ticks, ok, MinDelay, ArmMax);
        end
    endtask

    // Returns #1 after the posedge carrying the k-th tick.
    task automatic countTicks(input int k);
        int c;
        c = 0;
        while (c < k) begin
            @(posedge clk);
            if (ms_tick) c++;
        end
        #1;
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy still %0d, expected 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finishValid(input int k);
        int t;
        waitStim(t);
        countTicks(k);
        noteValid(k);
        pushExp(k, 1, 0, 0);
        pressStop();
        waitIdle();
    endtask

    task automatic runValid(input int k);
        pressStart();
        finishValid(k);
    endtask

    task automatic runEarly(input int d);
        pressStart();
        stimSeen = 1'b0;
        waitClk(d);
        pushExp(0, 0, 1, 0);
        pressStop();
        waitIdle();
        check("early_no_stim", int'(stimSeen), 0);
    endtask

    task automatic runTimeout();
        int t;
        pressStart();
        waitStim(t);
        pushExp(TimeoutMs, 0, 0, 1);
        waitIdle();
    endtask

    // Stop lands on the same clk as the tick after the k-th one.
    task automatic runCoincide(input int k);
        int t;
        pressStart();
        waitStim(t);
        countTicks(k);
        waitClk(9);
        noteValid(k);
        pushExp(k, 1, 0, 0);
        pressStop();
        waitIdle();
    endtask

    initial begin
        int r;
        // Reset values.
        reset = 1'b1;
        waitClk(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_stim_led", int'(stim_led), 0);
        check("rst_result_ms", int'(result_ms), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_early", int'(early), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_best_ms", int'(best_ms), 255);
        waitClk(2);

        // Basic measurement, then a stop in a terminal state is ignored.
        runValid(7);
        pressStop();
        waitClk(3);
        check("stop_ignored_busy", int'(busy), 0);
        check("stop_ignored_result", int'(result_ms), 7);
        check("stop_ignored_valid", int'(result_valid), 1);

        // Early press, then a new start clears early and re-arms.
        runEarly(int'($urandom_range(1, 25)));
        pressStart();
        @(negedge clk);
        check("rearm_early_clr", int'(early), 0);
        check("rearm_busy", int'(busy), 1);
        finishValid(3);

        runTimeout();
        runCoincide(5);

        // Start held through reset release produces no attempt.
        reset = 1'b1;
        start_btn = 1'b1;
        waitClk(3);
        reset = 1'b0;
        bestModel = 255;
        waitClk(30);
        @(negedge clk);
        check("held_start_busy", int'(busy), 0);
        check("held_start_stim", int'(stim_led), 0);
        @(posedge clk);
        #1;
        start_btn = 1'b0;
        waitClk(2);
        pressStart();
        @(negedge clk);
        check("repress_busy", int'(busy), 1);
        begin
            int t;
            waitStim(t);
        end
        countTicks(3);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midgo_rst_busy", int'(busy), 0);
        check("midgo_rst_stim", int'(stim_led), 0);
        check("midgo_rst_result", int'(result_ms), 0);
        check("midgo_rst_valid", int'(result_valid), 0);
        check("midgo_rst_early", int'(early), 0);
        check("midgo_rst_timeout", int'(timeout), 0);
        check("midgo_rst_best", int'(best_ms), 255);
        waitClk(2);
        reset = 1'b0;
        bestModel = 255;
        waitClk(2);

        // Best-result tracking sequence.
        runValid(9);
        runValid(12);
        runValid(6);

        // Randomised attempts.
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      runValid(int'($urandom_range(1, TimeoutMs - 1)));
            else if (r <= 7) runEarly(int'($urandom_range(1, 25)));
            else if (r == 8) runCoincide(int'($urandom_range(1, TimeoutMs - 1)));
            else             runTimeout();
        end
        runCoincide(TimeoutMs - 1);

        waitClk(5);
        check("queue_drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
